// File: rtl/motor_io_pkg.sv
// Shared types and helpers for the motor I/O hub: word width, bridge
// direction encodings, channel FSM states and duty magnitude clamp.
package motor_io_pkg;

  localparam int CH_W = 16;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_REV,
    ST_DEAD
  } ch_state_e;

  // |v| in one extra bit so -32768 is representable, then clamp to pmax.
  function automatic logic [CH_W:0] duty_mag(input logic [CH_W-1:0] v,
                                             input logic [CH_W:0]   pmax);
    logic [CH_W:0] a;
    a = v[CH_W-1] ? ({1'b1, {CH_W{1'b0}}} - {1'b0, v}) : {1'b0, v};
    return (a > pmax) ? pmax : a;
  endfunction

endpackage

// File: rtl/motor_io_hub_channel.sv
// One motor channel: duty latch, period-aligned apply, drive FSM with
// reversal dead-time, and a synchronised x4 quadrature counter.
module motor_channel
  import motor_io_pkg::*;
#(
  parameter int PWM_MAX  = 4096,
  parameter int ENC_MAX  = 64000,
  parameter int DEADTIME = 50,
  parameter int CNT_W    = 12
) (
  input  logic             fpga_clk_50,
  input  logic             hps_fpga_reset_n,
  input  logic             wr_i,
  input  logic [CH_W-1:0]  val_i,
  input  logic             wrap_i,
  input  logic             kill_i,
  input  logic [CNT_W-1:0] cnt_nxt_i,
  input  logic             enc_clr_i,
  input  logic             enc_a_i,
  input  logic             enc_b_i,
  output logic [CH_W-1:0]  enc_val_o,
  output logic             enc_err_o,
  output logic             pwm_o,
  output logic [1:0]       dir_o
);

  localparam int              PW        = CH_W + 1;
  localparam int              DW        = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0]   DEAD_LAST = DW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [CH_W-1:0] ENC_TOP   = CH_W'(ENC_MAX - 1);
  localparam logic [PW-1:0]   PMAX      = PW'(PWM_MAX);

  logic [CH_W-1:0] cmd_q, cmd_d, act_q, act_d;
  ch_state_e       st_q, st_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic            act_pos, act_neg, pwm_q, pwm_d;
  logic [1:0]      dir_q, dir_d;

  always_comb begin
    cmd_d = cmd_q;
    act_d = act_q;
    if (kill_i) begin
      cmd_d = '0;
      act_d = '0;
    end else begin
      if (wr_i)   cmd_d = val_i;
      if (wrap_i) act_d = cmd_q;
    end
  end

  assign act_neg = act_d[CH_W-1];
  assign act_pos = !act_d[CH_W-1] && (act_d != '0);

  // DEAD runs on its own counter; every other state only moves at the period wrap.
  always_comb begin
    st_d   = st_q;
    dead_d = dead_q;
    if (kill_i) begin
      st_d   = ST_IDLE;
      dead_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: if (wrap_i) st_d = act_pos ? ST_FWD : (act_neg ? ST_REV : ST_IDLE);
        ST_FWD: if (wrap_i) begin
          if (!act_pos && !act_neg) st_d = ST_IDLE;
          else if (act_neg) begin
            st_d   = (DEADTIME == 0) ? ST_REV : ST_DEAD;
            dead_d = '0;
          end
        end
        ST_REV: if (wrap_i) begin
          if (!act_pos && !act_neg) st_d = ST_IDLE;
          else if (act_pos) begin
            st_d   = (DEADTIME == 0) ? ST_FWD : ST_DEAD;
            dead_d = '0;
          end
        end
        ST_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            dead_d = '0;
            st_d   = act_pos ? ST_FWD : (act_neg ? ST_REV : ST_IDLE);
          end else begin
            dead_d = dead_q + DW'(1);
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_d = DIR_COAST;
    if (st_d == ST_FWD)      dir_d = DIR_FWD;
    else if (st_d == ST_REV) dir_d = DIR_REV;
  end

  // Pin outputs are registered from next-state so the bridge never sees decode glitches.
  assign pwm_d = ((st_d == ST_FWD) || (st_d == ST_REV)) &&
                 (PW'(cnt_nxt_i) < duty_mag(act_d, PMAX));

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      cmd_q  <= '0;
      act_q  <= '0;
      st_q   <= ST_IDLE;
      dead_q <= '0;
      pwm_q  <= 1'b0;
      dir_q  <= DIR_COAST;
    end else begin
      cmd_q  <= cmd_d;
      act_q  <= act_d;
      st_q   <= st_d;
      dead_q <= dead_d;
      pwm_q  <= pwm_d;
      dir_q  <= dir_d;
    end
  end

  assign pwm_o = pwm_q;
  assign dir_o = dir_q;

  // Encoder: 2-FF sync, registered step decode, then the modulo counter.
  logic [1:0]      s1_q, s2_q, prev_q;
  logic            inc_q, dec_q, bad_q, inc_d, dec_d, bad_d;
  logic [CH_W-1:0] ecnt_q, ecnt_d;
  logic            err_q, err_d;

  always_comb begin
    inc_d = 1'b0;
    dec_d = 1'b0;
    bad_d = ((prev_q ^ s2_q) == 2'b11);
    case ({prev_q, s2_q})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: inc_d = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ecnt_d = ecnt_q;
    err_d  = err_q;
    if (enc_clr_i) begin
      ecnt_d = '0;
      err_d  = 1'b0;
    end else begin
      if (inc_q)      ecnt_d = (ecnt_q == ENC_TOP) ? '0 : ecnt_q + CH_W'(1);
      else if (dec_q) ecnt_d = (ecnt_q == '0) ? ENC_TOP : ecnt_q - CH_W'(1);
      if (bad_q)      err_d  = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      bad_q  <= 1'b0;
      ecnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      s1_q   <= {enc_a_i, enc_b_i};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      bad_q  <= bad_d;
      ecnt_q <= ecnt_d;
      err_q  <= err_d;
    end
  end

  assign enc_val_o = ecnt_q;
  assign enc_err_o = err_q;

endmodule

// File: rtl/motor_io_hub.sv
// N-channel motor I/O hub: shared PWM period counter, command watchdog and
// bus packing around an array of motor_channel instances.
module motor_io_hub
  import motor_io_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int PWM_MAX     = 4096,
  parameter int ENC_MAX     = 64000,
  parameter int DEADTIME    = 50,
  parameter int WDOG_CYCLES = 5000000
) (
  input  logic                     fpga_clk_50,
  input  logic                     hps_fpga_reset_n,
  input  logic [CH_W*NUM_CH-1:0]   pwm_vals,
  input  logic                     pwm_wr,
  input  logic [NUM_CH-1:0]        enc_clr,
  input  logic [NUM_CH-1:0]        enc_a,
  input  logic [NUM_CH-1:0]        enc_b,
  output logic [CH_W*NUM_CH-1:0]   enc_vals,
  output logic [NUM_CH-1:0]        enc_err,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH-1:0]        dir_a,
  output logic [NUM_CH-1:0]        dir_b,
  output logic                     wdog_trip
);

  localparam int               CNT_W    = (PWM_MAX > 1) ? $clog2(PWM_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_MAX - 1);
  localparam int               WD_W     = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
  localparam bit               WD_EN    = (WDOG_CYCLES > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             trip_q, trip_d, expire;

  assign wrap  = (cnt_q == CNT_LAST);
  assign cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

  // A write in the expiry cycle wins; the counter parks once tripped.
  always_comb begin
    expire = WD_EN && !pwm_wr && !trip_q && (wd_q == WD_LAST);
    wd_d   = wd_q;
    trip_d = trip_q;
    if (pwm_wr) begin
      wd_d   = '0;
      trip_d = 1'b0;
    end else if (expire) begin
      trip_d = 1'b1;
    end else if (!trip_q && (wd_q != WD_LAST)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      cnt_q  <= '0;
      wd_q   <= '0;
      trip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wd_q   <= wd_d;
      trip_q <= trip_d;
    end
  end

  assign wdog_trip = trip_q;

  logic [NUM_CH-1:0][CH_W-1:0] vals_w, enc_w;
  logic [NUM_CH-1:0][1:0]      dir_w;

  assign vals_w   = pwm_vals;
  assign enc_vals = enc_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_channel #(
      .PWM_MAX (PWM_MAX),
      .ENC_MAX (ENC_MAX),
      .DEADTIME(DEADTIME),
      .CNT_W   (CNT_W)
    ) u_ch (
      .fpga_clk_50     (fpga_clk_50),
      .hps_fpga_reset_n(hps_fpga_reset_n),
      .wr_i            (pwm_wr),
      .val_i           (vals_w[i]),
      .wrap_i          (wrap),
      .kill_i          (expire),
      .cnt_nxt_i       (cnt_d),
      .enc_clr_i       (enc_clr[i]),
      .enc_a_i         (enc_a[i]),
      .enc_b_i         (enc_b[i]),
      .enc_val_o       (enc_w[i]),
      .enc_err_o       (enc_err[i]),
      .pwm_o           (pwm_out[i]),
      .dir_o           (dir_w[i])
    );
    assign dir_a[i] = dir_w[i][1];
    assign dir_b[i] = dir_w[i][0];
  end

endmodule
